// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared constants and FSM encoding for the BCD conversion scheduler.
// The converter is serial, so several requesters take turns on one instance.
package bcd_conv_scheduler_pkg;

  localparam int unsigned NumCh         = 4;
  localparam int unsigned OperandW      = 7;
  localparam int unsigned TimeoutCycles = 63;
  localparam int unsigned SatLimit      = 99;
  localparam int unsigned BcdW          = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StStore = 2'd3
  } state_e;

  // Two BCD digits can hold at most SatLimit.
  function automatic int unsigned saturate(input int unsigned value);
    return (value > SatLimit) ? SatLimit : value;
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter: one shift per cycle after start,
// pronto is high for one cycle once all W bits have been shifted in.
module bcd_conv_scheduler_bin2bcd #(
  parameter int unsigned W = 7,
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         pronto,
  output logic [N-1:0] bcd
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [N+W-1:0] sreg_q, sreg_d;
  logic [N+W-1:0] adj;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           active_q, active_d;

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    adj      = sreg_q;
    for (int d = 0; d < int'(N / 4); d++) begin
      if (adj[W+4*d +: 4] >= 4'd5) begin
        adj[W+4*d +: 4] = adj[W+4*d +: 4] + 4'd3;
      end
    end
    if (start) begin
      sreg_d   = {{N{1'b0}}, bin};
      cnt_d    = CW'(W);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        sreg_d = {adj[N+W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign pronto = active_q && (cnt_q == '0);
  assign bcd    = sreg_q[N+W-1:W];

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter among NUM_CH
// requesters, with per-channel result slots, saturation flags and a wait timeout.
module bcd_conv_scheduler
  import bcd_conv_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumCh,
  parameter int unsigned W       = OperandW,
  parameter int unsigned TIMEOUT = TimeoutCycles
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH*W-1:0]         binary,
  output logic [NUM_CH-1:0]           ack,
  output logic [NUM_CH*BcdW-1:0]      bcd,
  output logic [NUM_CH-1:0]           valid,
  output logic [NUM_CH-1:0]           ovf,
  output logic                        busy,
  output logic [$clog2(NUM_CH)-1:0]   grant,
  output logic                        erro
);

  localparam int unsigned GW = $clog2(NUM_CH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [W-1:0]             op_q, op_d;
  logic                     sat_q, sat_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  logic [NUM_CH-1:0]        ack_q, ack_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [NUM_CH*BcdW-1:0]   bcd_q, bcd_d;
  logic                     erro_q, erro_d;

  logic [GW-1:0]            rr_sel;
  logic                     rr_found;
  logic [W-1:0]             rr_op;

  logic                     conv_start;
  logic                     conv_pronto;
  logic [BcdW-1:0]          conv_bcd;

  // Search starts one past the last served channel so a held request cannot starve others.
  always_comb begin
    rr_sel   = grant_q;
    rr_found = 1'b0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      if (!rr_found && req[(int'(grant_q) + i) % int'(NUM_CH)]) begin
        rr_sel   = GW'((int'(grant_q) + i) % int'(NUM_CH));
        rr_found = 1'b1;
      end
    end
    rr_op = binary[int'(rr_sel)*W +: W];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_d    = op_q;
    sat_d   = sat_q;
    tcnt_d  = tcnt_q;
    ack_d   = '0;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    erro_d  = erro_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_sel;
          sat_d   = (32'(rr_op) > SatLimit);
          op_d    = W'(saturate(32'(rr_op)));
          state_d = StStart;
        end
      end
      StStart: begin
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (conv_pronto) begin
          bcd_d[int'(grant_q)*BcdW +: BcdW] = conv_bcd;
          valid_d[grant_q] = 1'b1;
          ovf_d[grant_q]   = sat_q;
          ack_d[grant_q]   = 1'b1;
          state_d          = StStore;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (32'(tcnt_q) + 32'd1 >= TIMEOUT) begin
            // Requester is released with an ack but its slot keeps the old result.
            erro_d         = 1'b1;
            ack_d[grant_q] = 1'b1;
            state_d        = StIdle;
          end
        end
      end
      StStore: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= GW'(NUM_CH - 1);
      op_q    <= '0;
      sat_q   <= 1'b0;
      tcnt_q  <= '0;
      ack_q   <= '0;
      bcd_q   <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
      tcnt_q  <= tcnt_d;
      ack_q   <= ack_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      erro_q  <= erro_d;
    end
  end

  assign conv_start = (state_q == StStart);

  bcd_conv_scheduler_bin2bcd #(
    .W (W),
    .N (BcdW)
  ) u_bin2bcd (
    .clock  (clock),
    .reset  (reset),
    .start  (conv_start),
    .bin    (op_q),
    .pronto (conv_pronto),
    .bcd    (conv_bcd)
  );

  assign ack   = ack_q;
  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != StIdle);
  assign grant = grant_q;
  assign erro  = erro_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: transaction-timing model checked every cycle plus
// directed scenarios with hand-computed results.
module tb_bcd_conv_scheduler;

  localparam int NCH      = 4;
  localparam int OW       = 7;
  localparam int TMO      = 63;
  localparam int LAT      = 3 + OW;       // request sample to ack, converter takes OW cycles
  localparam int TMO_LAT  = 1 + TMO + 1;  // START, TMO wait cycles, then ack

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] binary = '0;
  logic [3:0]  ack, valid, ovf;
  logic [31:0] bcd;
  logic        busy;
  logic [1:0]  grant;
  logic        erro;

  bcd_conv_scheduler dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .binary (binary),
    .ack    (ack),
    .bcd    (bcd),
    .valid  (valid),
    .ovf    (ovf),
    .busy   (busy),
    .grant  (grant),
    .erro   (erro)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Model: one transaction at a time, described by its grant cycle and ack cycle.
  bit          model_on = 0;
  bit          stall    = 0;
  bit          m_active, m_to, m_sat, m_erro;
  int          m_ch, m_val, m_start, m_ack_at, m_grant;
  logic [31:0] m_bcd;
  logic [3:0]  m_valid, m_ovf, m_ack;

  task automatic model_reset();
    m_active = 0;
    m_to     = 0;
    m_erro   = 0;
    m_grant  = NCH - 1;
    m_bcd    = '0;
    m_valid  = '0;
    m_ovf    = '0;
  endtask

  always @(negedge clock) begin
    bit fsm_idle, exp_busy;
    int ch, op;
    if (model_on) begin
      m_ack = '0;
      if (m_active && cyc == m_ack_at) begin
        m_ack[m_ch] = 1'b1;
        if (m_to) begin
          m_erro = 1;
        end else begin
          m_bcd[m_ch*8 +: 8] = to_bcd(m_val);
          m_valid[m_ch]      = 1'b1;
          m_ovf[m_ch]        = m_sat;
        end
      end
      exp_busy = m_active && cyc >= m_start && (cyc < m_ack_at || (!m_to && cyc == m_ack_at));
      check("m_ack",   32'(ack),   32'(m_ack));
      check("m_bcd",   bcd,        m_bcd);
      check("m_valid", 32'(valid), 32'(m_valid));
      check("m_ovf",   32'(ovf),   32'(m_ovf));
      check("m_busy",  32'(busy),  32'(exp_busy));
      check("m_grant", 32'(grant), 32'(m_grant));
      check("m_erro",  32'(erro),  32'(m_erro));
    end
    if (reset) begin
      model_reset();
      model_on = 1;
    end else if (model_on) begin
      fsm_idle = !m_active || (m_to ? cyc >= m_ack_at : cyc > m_ack_at);
      if (fsm_idle) begin
        m_active = 0;
        for (int i = 1; i <= NCH; i++) begin
          ch = (m_grant + i) % NCH;
          if (!m_active && req[ch]) begin
            op       = int'(binary[ch*OW +: OW]);
            m_active = 1;
            m_ch     = ch;
            m_grant  = ch;
            m_sat    = op > 99;
            m_val    = m_sat ? 99 : op;
            m_to     = stall;
            m_start  = cyc + 1;
            m_ack_at = cyc + (stall ? TMO_LAT : LAT);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int ch, input int v);
    binary[ch*OW +: OW] = OW'(v);
  endtask

  task automatic request(input logic [3:0] mask, output int at);
    req = mask;
    at  = cyc;
    step();
    req = '0;
  endtask

  task automatic wait_ack(input int limit, output int at, output logic [3:0] vec);
    at  = -1;
    vec = '0;
    for (int i = 0; i < limit && at < 0; i++) begin
      @(negedge clock);
      if (ack != '0) begin
        at  = cyc;
        vec = ack;
      end
    end
    check("ack_seen", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_req, t_ack;
    logic [3:0] v;

    repeat (3) step();
    reset = 1'b0;

    // Single request, ch0 = 42
    set_op(0, 42);
    request(4'b0001, t_req);
    wait_ack(40, t_ack, v);
    check("t1_lat",   32'(t_ack - t_req), 32'd10);
    check("t1_ack",   32'(v),       32'h1);
    check("t1_bcd",   32'(bcd[7:0]), 32'h42);
    check("t1_valid", 32'(valid),   32'h1);
    check("t1_ovf",   32'(ovf),     32'h0);
    step();

    // All four held, round-robin order from channel 0
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_op(0, 1);
    set_op(1, 2);
    set_op(2, 3);
    set_op(3, 4);
    req   = 4'hF;
    t_req = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_ack(40, t_ack, v);
      check("rr_order", 32'(v), 32'(4'b0001 << (i % 4)));
      if (i == 0) check("rr_lat", 32'(t_ack - t_req), 32'(LAT));
      if (i == 3) check("rr_bcd", bcd, 32'h04030201);
    end
    step();
    req = '0;
    check("rr_valid", 32'(valid), 32'hF);

    // Saturation then recovery on ch2
    step();
    set_op(2, 127);
    request(4'b0100, t_req);
    wait_ack(40, t_ack, v);
    check("sat_bcd", 32'(bcd[23:16]), 32'h99);
    check("sat_ovf", 32'(ovf), 32'h4);
    step();
    set_op(2, 5);
    request(4'b0100, t_req);
    wait_ack(40, t_ack, v);
    check("unsat_bcd", 32'(bcd[23:16]), 32'h05);
    check("unsat_ovf", 32'(ovf), 32'h0);
    step();

    // Operand change while waiting must not affect the result
    set_op(1, 10);
    request(4'b0010, t_req);
    repeat (3) step();
    set_op(1, 77);
    wait_ack(40, t_ack, v);
    check("latch_bcd", 32'(bcd[15:8]), 32'h10);
    step();

    // Converter never completes: timeout path
    stall = 1;
    force dut.conv_pronto = 1'b0;
    set_op(3, 50);
    request(4'b1000, t_req);
    wait_ack(100, t_ack, v);
    check("to_lat",   32'(t_ack - t_req), 32'd65);
    check("to_ack",   32'(v), 32'h8);
    check("to_erro",  32'(erro), 32'h1);
    check("to_valid", 32'(valid), 32'hF);
    check("to_slot",  32'(bcd[31:24]), 32'h04);
    check("to_idle",  32'(busy), 32'h0);
    step();
    release dut.conv_pronto;
    stall = 0;

    // Reset while waiting aborts the conversion
    set_op(0, 30);
    request(4'b0001, t_req);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_ack",   32'(ack), 32'h0);
    check("rst_bcd",   bcd, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ovf",   32'(ovf), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_grant", 32'(grant), 32'h3);
    check("rst_erro",  32'(erro), 32'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      check("rst_no_ack", 32'(ack), 32'h0);
    end
    step();

    // Saturation boundary: 99 passes, 100 saturates
    set_op(1, 99);
    request(4'b0010, t_req);
    wait_ack(40, t_ack, v);
    check("b99_bcd", 32'(bcd[15:8]), 32'h99);
    check("b99_ovf", 32'(ovf), 32'h0);
    step();
    set_op(2, 100);
    request(4'b0100, t_req);
    wait_ack(40, t_ack, v);
    check("b100_bcd", 32'(bcd[23:16]), 32'h99);
    check("b100_ovf", 32'(ovf), 32'h4);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesters sharing one converter.
REQ-002 Parameter W, default 7: binary operand width per channel.
REQ-003 Parameter TIMEOUT, default 63: maximum cycles spent waiting for converter completion.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_CH  level request per channel; bit i asks for conversion of channel i.
REQ-007 binary  in  NUM_CH*W  packed operands; channel i at bits [i*W +: W].
REQ-008 ack  out  NUM_CH  one-cycle pulse on bit i when channel i's result is stored.
REQ-009 bcd  out  NUM_CH*8  packed results; two BCD digits per channel, tens digit high.
REQ-010 valid  out  NUM_CH  bit i high once channel i holds a result since reset.
REQ-011 ovf  out  NUM_CH  bit i high when channel i's last operand exceeded 99.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 grant  out  2  index of the channel currently or most recently served.
REQ-014 erro  out  1  sticky flag, set on converter timeout.

Function
REQ-015 FSM states: IDLE, START, WAIT, STORE; the FSM SHALL leave reset in IDLE.
REQ-016 IDLE, any req bit high: select the first requesting channel in round-robin order starting at grant+1 (mod NUM_CH), latch its operand and index, then go to START.
REQ-017 IDLE, no req bit high: remain in IDLE.
REQ-018 Operand rule: an operand greater than 99 SHALL be saturated to 99 before conversion, and ovf[ch] is set; otherwise ovf[ch] is cleared at STORE.
REQ-019 START: assert the converter start pulse for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-020 WAIT: on converter pronto, go to STORE; otherwise increment the timeout counter.
REQ-021 WAIT timeout: when the counter reaches TIMEOUT without pronto, set erro, pulse ack[ch] without updating bcd or valid, and return to IDLE.
REQ-022 STORE: write the converter BCD to the bcd slot of the granted channel, set valid[ch], pulse ack[ch], then go to IDLE (1 cycle).
REQ-023 Latency: ack follows converter pronto by exactly 1 cycle; from request sampled in IDLE, the minimum latency is 3 cycles plus the converter latency.
REQ-024 The operand latched at grant SHALL be used even if binary or req changes during conversion; a conversion in progress always completes.
REQ-025 A channel that keeps req high after its ack is rescheduled only after every other pending channel has been served once (no starvation).
REQ-026 bcd slots of non-granted channels SHALL never change.

Reset
REQ-027 On reset: state IDLE, ack=0, bcd=0, valid=0, ovf=0, busy=0, grant=NUM_CH-1 (so channel 0 wins first), erro=0, timeout counter=0.
REQ-028 Reset asserted mid-conversion SHALL abort it: no ack, no store, and any later converter pronto is ignored until a new START.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, NUM_CH, W, TIMEOUT and the saturation limit 99.
REQ-030 The block SHALL contain exactly one sub-module instance: the existing bin2bcd converter with W=7, N=8, driven by the internal start pulse and returning pronto and the 8-bit BCD result.

Verification
REQ-031 Reset, then req=0001 with ch0=42 -> ack=0001 one cycle after pronto, bcd[7:0]=0x42, valid=0001, ovf=0000.
REQ-032 req=1111 held with operands 1,2,3,4 -> acks in order ch0, ch1, ch2, ch3, ch0...; bcd slots hold 0x01, 0x02, 0x03, 0x04.
REQ-033 ch2=127 requested -> bcd slot 2 holds 0x99, ovf[2]=1; a following request with ch2=5 -> slot 2 holds 0x05, ovf[2]=0.
REQ-034 ch1 operand changed from 10 to 77 during WAIT -> slot 1 holds 0x10.
REQ-035 Converter pronto forced low -> erro=1 after 63 WAIT cycles, ack pulses, valid unchanged, FSM back in IDLE.
REQ-036 Reset asserted during WAIT -> all outputs at their reset values the next cycle and no ack.
